// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Desc     : Shared constants, FSM state encoding and elaboration-time helper
//            functions for the BCD-to-binary converter.
// Revision : 1.0  initial release
// ============================================================================
package bcd_pkg;

    // Default number of packed BCD digits (hundreds/tens/ones)
    localparam int DEFAULT_DIGITS = 3;

    // Largest legal value of a single BCD digit
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input longint unsigned v);
        int r;
        longint unsigned x;
        r = 0;
        x = (v > 0) ? v - 1 : 0;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // 10 to the power n, used to size the binary accumulator
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Desc     : Single-digit correction for reverse double dabble. After a right
//            shift, a digit of 8 or more has borrowed a 1 that was worth 10
//            rather than 16 in the digit above, so 3 is subtracted.
// Revision : 1.0  initial release
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd8) ? (d - 4'd3) : d;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Desc     : Sequential BCD-to-binary converter (reverse double dabble), one
//            shift-and-correct step per clock. Result, overflow and error
//            flags are valid in the done cycle and held until replaced by the
//            next conversion result.
// Options  : BCD2BIN_SAT_EN - when defined, an overflowing result saturates
//            bin to all ones; otherwise bin is the value modulo 2^BIN_W.
// Revision : 1.0  initial release
// ============================================================================
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEFAULT_DIGITS,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin,
    output logic                  ovf,
    output logic                  err
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_ACC_W = clog2(pow10(DIGITS));
    localparam int c_CNT_W = clog2(c_ACC_W + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_BCD_W-1:0]   r_bcd;
    logic [c_BCD_W-1:0]   w_bcd_sh;
    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [c_ACC_W-1:0]   r_acc;
    logic [c_ACC_W-1:0]   w_acc_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [DIGITS-1:0]    w_digit_bad;
    logic                 w_in_bad;
    logic                 w_last_step;
    logic                 w_ovf;
    logic [BIN_W-1:0]     w_bin_trunc;
    logic [BIN_W-1:0]     w_bin_res;
    logic                 r_busy;
    logic [BIN_W-1:0]     r_bin;
    logic                 r_ovf;
    logic                 r_err;

    // One right shift of the work register {r_bcd, r_acc}
    assign w_bcd_sh   = {1'b0, r_bcd[c_BCD_W-1:1]};
    assign w_acc_next = {r_bcd[0], r_acc[c_ACC_W-1:1]};

    // Per-digit input validation and post-shift correction
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_digit_bad[gi] = (bcd[4*gi +: 4] > BCD_DIGIT_MAX);

            bcd_digit_adj u_adj (
                .d (w_bcd_sh[4*gi +: 4]),
                .q (w_bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign w_in_bad    = |w_digit_bad;
    assign w_last_step = (r_cnt == c_CNT_W'(c_ACC_W - 1));

    // Overflow detection and truncated result from the final accumulator value
    assign w_bin_trunc = BIN_W'(w_acc_next);
    generate
        if (BIN_W >= c_ACC_W) begin : g_ovf_none
            assign w_ovf = 1'b0;
        end else begin : g_ovf_chk
            assign w_ovf = |w_acc_next[c_ACC_W-1:BIN_W];
        end
    endgenerate

`ifdef BCD2BIN_SAT_EN
    assign w_bin_res = w_ovf ? {BIN_W{1'b1}} : w_bin_trunc;
`else
    assign w_bin_res = w_bin_trunc;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = w_in_bad ? ERR : SHIFT;
            SHIFT:   if (w_last_step) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift/correct per step, latch results
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bcd  <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_bin  <= '0;
            r_ovf  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (w_in_bad) begin
                            r_err <= 1'b1;
                            r_ovf <= 1'b0;
                            r_bin <= '0;
                        end else begin
                            r_bcd  <= bcd;
                            r_acc  <= '0;
                            r_cnt  <= '0;
                            r_busy <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd <= w_bcd_adj;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_last_step) begin
                        r_busy <= 1'b0;
                        r_bin  <= w_bin_res;
                        r_ovf  <= w_ovf;
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = (r_state == DONE) || (r_state == ERR);
    assign bin  = r_bin;
    assign ovf  = r_ovf;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Desc     : Self-checking bench for bcd_to_bin with a result scoreboard.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_to_bin;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic [11:0] bcd   = '0;
    logic        busy;
    logic        done;
    logic [7:0]  bin;
    logic        ovf;
    logic        err;

    typedef struct packed {
        logic [7:0] bin;
        logic       ovf;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd_to_bin dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .ovf   (ovf),
        .err   (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Wait for done starting at cycle offset n0 (1 = first cycle after accept),
    // check busy while waiting, latency, then pop and compare the result.
    task automatic wait_done(input string tag, input int n0, input int lat);
        int   n;
        exp_t e;
        n = n0;
        while (done !== 1'b1 && n < 40) begin
            chk({tag, ":busy"}, 32'(busy), 32'd1);
            tick();
            n++;
        end
        chk({tag, ":latency"}, n, lat);
        chk({tag, ":busy_at_done"}, 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, ":sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ":bin"}, 32'(bin), 32'(e.bin));
            chk({tag, ":ovf"}, 32'(ovf), 32'(e.ovf));
            chk({tag, ":err"}, 32'(err), 32'(e.err));
        end
    endtask

    // Full conversion: push expectation, pulse start, scramble input, check
    task automatic conv(input string tag, input logic [11:0] v, input logic [7:0] eb,
                        input logic eo, input logic ee, input int lat);
        logic [7:0] hold_bin;
        sb.push_back({eb, eo, ee});
        bcd   = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        bcd   = 12'h777;
        wait_done(tag, 1, lat);
        hold_bin = bin;
        tick();
        chk({tag, ":done_pulse"}, 32'(done), 32'd0);
        chk({tag, ":bin_hold"}, 32'(bin), 32'(hold_bin));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;

        // Reset state
        rst = 1'b0;
        tick(); tick(); tick();
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:done", 32'(done), 32'd0);
        chk("rst:bin",  32'(bin),  32'd0);
        chk("rst:ovf",  32'(ovf),  32'd0);
        chk("rst:err",  32'(err),  32'd0);
        rst = 1'b1;
        tick();

        // Main function
        conv("c255", 12'h255, 8'hFF, 1'b0, 1'b0, 11);
        conv("c000", 12'h000, 8'h00, 1'b0, 1'b0, 11);
        conv("c127", 12'h127, 8'h7F, 1'b0, 1'b0, 11);
`ifdef BCD2BIN_SAT_EN
        conv("c999", 12'h999, 8'hFF, 1'b1, 1'b0, 11);
        conv("c256", 12'h256, 8'hFF, 1'b1, 1'b0, 11);
`else
        conv("c999", 12'h999, 8'hE7, 1'b1, 1'b0, 11);
        conv("c256", 12'h256, 8'h00, 1'b1, 1'b0, 11);
`endif
        conv("c1A3", 12'h1A3, 8'h00, 1'b0, 1'b1, 1);
        conv("c042", 12'h042, 8'h2A, 1'b0, 1'b0, 11);

        // Start during busy is ignored
        sb.push_back({8'h64, 1'b0, 1'b0});
        bcd   = 12'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        bcd   = 12'h050;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_start", 4, 11);

        // Start in the DONE cycle is ignored
        bcd   = 12'h050;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start:busy", 32'(busy), 32'd0);
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) dcount++;
            tick();
        end
        chk("done_start:extra_done", dcount, 0);
        chk("done_start:bin", 32'(bin), 32'h64);

        // Reset mid-operation after a result with nonzero flags
`ifdef BCD2BIN_SAT_EN
        conv("pre_rst", 12'h999, 8'hFF, 1'b1, 1'b0, 11);
`else
        conv("pre_rst", 12'h999, 8'hE7, 1'b1, 1'b0, 11);
`endif
        bcd   = 12'h255;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:done", 32'(done), 32'd0);
        chk("midrst:bin",  32'(bin),  32'd0);
        chk("midrst:ovf",  32'(ovf),  32'd0);
        chk("midrst:err",  32'(err),  32'd0);
        rst = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1 || busy === 1'b1) dcount++;
            tick();
        end
        chk("midrst:no_activity", dcount, 0);
        conv("post_rst", 12'h042, 8'h2A, 1'b0, 1'b0, 11);

        chk("sb:drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_to_bin.md
Name: bcd_to_bin

Overview:
- Sequential BCD-to-binary converter; the inverse of the display-path binary-to-BCD block.
- Converts DIGITS packed BCD digits (hundreds/tens/ones for the default) into a BIN_W-bit binary value.
- Uses reverse double dabble: one shift-and-correct step per clock.
- Sits between BCD-entry logic (time/alarm setting) and the binary counters of the watch core.

Parameters:
- DIGITS, 3, number of BCD input digits (MSD in the top nibble).
- BIN_W, 8, width of the binary output.

Ports:
- clk    input   1           system clock, rising-edge.
- rst    input   1           synchronous, active-low reset.
- start  input   1           request conversion; sampled only in IDLE.
- bcd    input   4*DIGITS    packed BCD input; [3:0] = ones, [7:4] = tens, [11:8] = hundreds.
- busy   output  1           high while a conversion is in progress.
- done   output  1           one-cycle pulse; results valid in that cycle.
- bin    output  BIN_W       converted value.
- ovf    output  1           value exceeds 2^BIN_W-1.
- err    output  1           some input digit > 9.

Behaviour:
- Reset and clocking: one clock. Reset is synchronous, active-low.
- Reset values: state=IDLE, busy=0, done=0, bin=0, ovf=0, err=0, shift counter=0.
- Width constants:
  - ACC_W = clog2(10^DIGITS); ACC_W = 10 for DIGITS = 3.
  - Work register = {bcd_r[4*DIGITS-1:0], acc[ACC_W-1:0]}.
- IDLE: start=1 samples bcd.
  - Any nibble > 9: next state ERR.
  - Otherwise: bcd_r<=bcd, acc<=0, cnt<=0, busy<=1, next state SHIFT.
- SHIFT, one step per cycle:
  - Shift the whole work register right by 1.
  - Then every digit of bcd_r that is >= 8 has 3 subtracted (applied to the shifted value, same cycle).
  - cnt increments; after ACC_W steps, next state DONE.
- DONE, one cycle:
  - done=1, busy=0.
  - ovf = (acc > 2^BIN_W-1); err=0.
  - bin per the optional feature.
  - Next state IDLE.
- ERR, one cycle: done=1, err=1, ovf=0, bin=0, busy=0; next state IDLE.
- Latency, start high in cycle T:
  - Valid input: done in cycle T+ACC_W+1 (T+11 for default).
  - Invalid digit: done in cycle T+1.
- Hold: bin/ovf/err hold their values after done until the next accepted start.
- Start outside IDLE, including the DONE/ERR cycle: ignored, no queuing.
- Back-to-back: start may be asserted in the cycle after done; accepted.
- Input stability: bcd is captured at accept; later input changes do not affect the conversion.
- Reset mid-operation: abort, return to reset values, no done pulse.

Optional Feature:
- Macro: BCD2BIN_SAT_EN.
- Defined: on overflow, bin saturates to all ones (2^BIN_W-1).
- Undefined: bin = acc[BIN_W-1:0] (truncated, modulo 2^BIN_W).
- ovf is asserted identically in both builds.

Decomposition:
- Package bcd_pkg:
  - BCD_DIGIT_MAX = 4'd9.
  - State enum {IDLE, SHIFT, DONE, ERR}.
  - Constant function clog2.
  - Default DIGITS.
- Sub-module bcd_digit_adj: 4-bit combinational correction (d >= 8 ? d-3 : d), instantiated DIGITS times via generate.

Test Plan:
- bcd=0x255 pulse start -> done exactly 11 cycles later, bin=0xFF, ovf=0, err=0; busy high for cycles T+1..T+10.
- bcd=0x000 -> bin=0x00; bcd=0x127 -> bin=0x7F; both with 11-cycle latency.
- bcd=0x999 -> ovf=1; bin=0xFF with BCD2BIN_SAT_EN, 0xE7 without. bcd=0x256 -> ovf=1; bin=0xFF (SAT) / 0x00 (no SAT).
- bcd=0x1A3 -> done at T+1, err=1, bin=0, ovf=0.
- Ignored starts:
  - Start 0x100, then start 0x050 pulsed during busy -> single done, bin=0x64.
  - Start in the DONE cycle also ignored.
- rst=0 at T+5 of a conversion -> next cycle all outputs zero, no done.
  - New start 0x042 after release -> bin=0x2A.
